cp0_except_pack: RTL

Exception collector and encoder at the EX/MEM boundary of the MIPS pipeline. It registers one instruction per cycle and tracks whether that instruction sits in a branch delay slot. It checks load/store alignment, resolves exception priority, and drives the packed 15-bit `excepttype` bus, `current_pc`, `bad_addr` and `rt_rdata` consumed by CP0. After any exception or `eret` it squashes younger instructions for a fixed number of cycles while the redirect to CP0's `new_pc` takes effect.

---
 rtl/cp0_except_pack_if.sv | 56 +++++
 rtl/cp0_except_pack.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cp0_except_pack_if.sv
// ============================================================================
// Module      : cp0_except_pack_if
// Description : EX/MEM-to-CP0 exception packing bus (pipeline side + CP0 side)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_except_pack_if;
    // Pipeline-side request
    logic        stall;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_is_branch;
    logic        in_syscall;
    logic        in_break;
    logic        in_invalid;
    logic        in_overflow;
    logic        in_eret;
    logic        in_mfc0;
    logic        in_mtc0;
    logic [4:0]  in_cp0_addr;
    logic        in_load;
    logic        in_store;
    logic [1:0]  in_mem_size;
    logic [31:0] in_mem_addr;
    logic [31:0] in_rt_rdata;

    // Packed result toward CP0 and memory stage
    logic [14:0] excepttype;
    logic [31:0] current_pc;
    logic [31:0] bad_addr;
    logic [31:0] rt_rdata;
    logic        out_valid;
    logic        mem_en;
    logic        squash;

    modport master (
        output stall, in_valid, in_pc, in_is_branch,
               in_syscall, in_break, in_invalid, in_overflow,
               in_eret, in_mfc0, in_mtc0, in_cp0_addr,
               in_load, in_store, in_mem_size, in_mem_addr, in_rt_rdata,
        input  excepttype, current_pc, bad_addr, rt_rdata,
               out_valid, mem_en, squash
    );

    modport slave (
        input  stall, in_valid, in_pc, in_is_branch,
               in_syscall, in_break, in_invalid, in_overflow,
               in_eret, in_mfc0, in_mtc0, in_cp0_addr,
               in_load, in_store, in_mem_size, in_mem_addr, in_rt_rdata,
        output excepttype, current_pc, bad_addr, rt_rdata,
               out_valid, mem_en, squash
    );
endinterface

`default_nettype wire

// File: rtl/cp0_except_pack.sv
// ============================================================================
// Module      : cp0_except_pack
// Description : EX/MEM exception collector/encoder feeding CP0, with
//               post-exception squash window. Optional data alignment
//               checking is enabled by defining CP0_DATA_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_except_pack #(
    parameter int SQUASH_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    cp0_except_pack_if.slave   bus
);

    localparam logic [3:0] c_sq_load = 4'(SQUASH_CYCLES);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_branch_q;
    logic        valid_q;
    logic [14:0] et_q;
    logic [31:0] pc_q;
    logic [31:0] bad_q;
    logic [31:0] rt_q;
    logic        mem_q;

    logic        fetch_adel;
    logic        data_adel;
    logic        data_ades;
    logic [14:0] et_d;
    logic [31:0] bad_d;
    logic        issue;
    logic        accept_en;

    // ------------------------------------------------------------------
    // Data alignment checking
    // ------------------------------------------------------------------
    logic misaligned;

    always_comb begin
        case (bus.in_mem_size)
            2'b01:   misaligned = bus.in_mem_addr[0];
            2'b10:   misaligned = |bus.in_mem_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef CP0_DATA_ALIGN_CHECK_EN
    assign data_adel = bus.in_load  & misaligned;
    assign data_ades = bus.in_store & misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign data_adel = 1'b0;
    assign data_ades = 1'b0;
`endif

    assign fetch_adel = |bus.in_pc[1:0];

    // ------------------------------------------------------------------
    // Priority encode of the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        et_d  = '0;
        bad_d = '0;
        if (fetch_adel) begin
            et_d[7] = 1'b1;
            bad_d   = bus.in_pc;
        end else if (bus.in_invalid) begin
            et_d[3] = 1'b1;
        end else if (bus.in_syscall) begin
            et_d[5] = 1'b1;
        end else if (bus.in_break) begin
            et_d[4] = 1'b1;
        end else if (bus.in_overflow) begin
            et_d[6] = 1'b1;
        end else if (data_adel) begin
            et_d[7] = 1'b1;
            bad_d   = bus.in_mem_addr;
        end else if (data_ades) begin
            et_d[8] = 1'b1;
            bad_d   = bus.in_mem_addr;
        end

        if (et_d[8:3] == 6'b0) begin
            et_d[2] = bus.in_eret;
            et_d[1] = bus.in_mfc0;
            et_d[0] = bus.in_mtc0;
            if (bus.in_mfc0 | bus.in_mtc0) begin
                et_d[14:10] = bus.in_cp0_addr;
            end
        end

        et_d[9] = last_branch_q;
    end

    assign issue = valid_q & (|et_q[8:2]);

    // The final SQUASH cycle (counter at 1) already accepts, so a new
    // instruction lands SQUASH_CYCLES+1 edges after the issue cycle.
    assign accept_en = (state_q == ST_RUN) | (cnt_q == 4'd1);

    // ------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= 4'd0;
            last_branch_q <= 1'b0;
            valid_q       <= 1'b0;
            et_q          <= '0;
            pc_q          <= '0;
            bad_q         <= '0;
            rt_q          <= '0;
            mem_q         <= 1'b0;
        end else if (issue) begin
            state_q       <= ST_SQUASH;
            cnt_q         <= c_sq_load;
            last_branch_q <= 1'b0;
            valid_q       <= 1'b0;
            et_q          <= '0;
            pc_q          <= '0;
            bad_q         <= '0;
            rt_q          <= '0;
            mem_q         <= 1'b0;
        end else begin
            if (state_q == ST_SQUASH) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_q <= ST_RUN;
                end
            end

            if (accept_en && !bus.stall) begin
                if (bus.in_valid) begin
                    valid_q       <= 1'b1;
                    et_q          <= et_d;
                    pc_q          <= bus.in_pc;
                    bad_q         <= bad_d;
                    rt_q          <= bus.in_rt_rdata;
                    mem_q         <= bus.in_load | bus.in_store;
                    last_branch_q <= bus.in_is_branch;
                end else begin
                    valid_q <= 1'b0;
                    et_q    <= '0;
                    pc_q    <= '0;
                    bad_q   <= '0;
                    rt_q    <= '0;
                    mem_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.excepttype = et_q;
    assign bus.current_pc = pc_q;
    assign bus.bad_addr   = bad_q;
    assign bus.rt_rdata   = rt_q;
    assign bus.out_valid  = valid_q;
    assign bus.squash     = issue;
    assign bus.mem_en     = valid_q & mem_q & ~(|et_q[8:3]);

endmodule

`default_nettype wire
